// File: rtl/levit_stage_sequencer.sv
// levit_stage_sequencer
// ---------------------
// Central sequencer for the Tiny LeViT inference chain. Twelve stages run
// one at a time, in order: conv16, conv8, conv4, 2-head stages 1-4,
// 4-head stages 5-8, then avg pool. Exactly one stage gets a level enable.
// The FSM moves to the next stage when the active stage pulses its end bit.
// A per-stage watchdog, an abort path and cycle-count profiling registers
// support bring-up.
//
// Handshake semantics: start, abort and stage_end are single-cycle
// requests. They are sampled on the rising clock edge. No ready is
// returned: a request either takes effect at that edge or is dropped.
//
// Ports
//   clk            system clock
//   rstn           asynchronous active-low reset
//   start          frame start request, honoured in IDLE or ERR
//   abort          synchronous abort, honoured in every state
//   stage_end      per-stage end pulse; bit i comes from stage i
//   stage_en       one-hot (or zero) registered stage enable
//   cur_stage      index of the active stage, or of the last stage run
//   busy           high while in RUN or GAP
//   done           one-cycle pulse after the last stage ends
//   err_timeout    sticky watchdog-expiry flag
//   err_spurious   sticky flag: a non-current stage_end bit arrived in RUN
//   stage_cyc_last enabled-cycle count of the most recently completed stage
//   frame_cyc      saturating cycle count from start acceptance to done
//   state_dbg      current FSM state, for debug and checkers
module levit_stage_sequencer #(
    parameter int N_STAGE     = 12,
    parameter int GAP_CYC     = 1,
    parameter int TIMEOUT_CYC = 65535,
    parameter int CNT_W       = 24
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic               abort,
    input  logic [N_STAGE-1:0] stage_end,
    output logic [N_STAGE-1:0] stage_en,
    output logic [3:0]         cur_stage,
    output logic               busy,
    output logic               done,
    output logic               err_timeout,
    output logic               err_spurious,
    output logic [15:0]        stage_cyc_last,
    output logic [CNT_W-1:0]   frame_cyc,
    output logic [2:0]         state_dbg
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RUN  = 3'd1;
    localparam logic [2:0] S_GAP  = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    localparam logic [3:0]         LAST_IDX  = 4'(N_STAGE - 1);
    // The GAP countdown is loaded with GAP_CYC-1, so GAP lasts exactly GAP_CYC cycles.
    localparam logic [3:0]         GAP_LOAD  = 4'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [15:0]        TIMEOUT_L = 16'(TIMEOUT_CYC);
    localparam logic [N_STAGE-1:0] EN_ONE    = N_STAGE'(1);
    localparam logic [CNT_W-1:0]   FRAME_ONE = CNT_W'(1);

    logic [2:0]         state_q, state_d;
    logic [3:0]         idx_q, idx_d;
    logic [N_STAGE-1:0] en_q, en_d;
    logic [15:0]        scnt_q, scnt_d;
    logic [3:0]         gap_q, gap_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_to_q, err_to_d;
    logic               err_sp_q, err_sp_d;
    logic [15:0]        last_q, last_d;
    logic [CNT_W-1:0]   frame_q, frame_d;

    logic [N_STAGE-1:0] cur_mask;
    logic               cur_end;
    logic               spur;
    logic [15:0]        scnt_inc;
    logic [CNT_W-1:0]   frame_inc;
    logic [3:0]         idx_nxt;

    always_comb begin
        cur_mask  = EN_ONE << idx_q;
        cur_end   = |(stage_end & cur_mask);
        spur      = |(stage_end & ~cur_mask);
        scnt_inc  = (scnt_q == 16'hFFFF) ? scnt_q : scnt_q + 16'd1;
        frame_inc = (&frame_q) ? frame_q : frame_q + FRAME_ONE;
        idx_nxt   = idx_q + 4'd1;
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        en_d     = en_q;
        scnt_d   = scnt_q;
        gap_d    = gap_q;
        done_d   = 1'b0;
        err_to_d = err_to_q;
        err_sp_d = err_sp_q;
        last_d   = last_q;
        frame_d  = frame_q;

        if (abort) begin
            // Flags, cur_stage and profiling counters are retained for post-mortem.
            state_d = S_IDLE;
            en_d    = '0;
        end else begin
            case (state_q)
                S_IDLE, S_ERR: begin
                    if (start) begin
                        state_d  = S_RUN;
                        idx_d    = 4'd0;
                        en_d     = EN_ONE;
                        scnt_d   = 16'd1;
                        frame_d  = FRAME_ONE;
                        err_to_d = 1'b0;
                        err_sp_d = 1'b0;
                    end
                end
                S_RUN: begin
                    if (spur) begin
                        err_sp_d = 1'b1;
                    end
                    // End is tested before the watchdog, so it wins a same-cycle tie.
                    if (cur_end) begin
                        en_d   = '0;
                        last_d = scnt_q;
                        if (idx_q == LAST_IDX) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else if (GAP_CYC == 0) begin
                            idx_d   = idx_nxt;
                            en_d    = EN_ONE << idx_nxt;
                            scnt_d  = 16'd1;
                            frame_d = frame_inc;
                        end else begin
                            state_d = S_GAP;
                            gap_d   = GAP_LOAD;
                            frame_d = frame_inc;
                        end
                    end else if (scnt_q >= TIMEOUT_L) begin
                        state_d  = S_ERR;
                        en_d     = '0;
                        err_to_d = 1'b1;
                    end else begin
                        scnt_d  = scnt_inc;
                        frame_d = frame_inc;
                    end
                end
                S_GAP: begin
                    frame_d = frame_inc;
                    if (gap_q == 4'd0) begin
                        state_d = S_RUN;
                        idx_d   = idx_nxt;
                        en_d    = EN_ONE << idx_nxt;
                        scnt_d  = 16'd1;
                    end else begin
                        gap_d = gap_q - 4'd1;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    en_d    = '0;
                end
            endcase
        end

        busy_d = (state_d == S_RUN) || (state_d == S_GAP);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            idx_q    <= 4'd0;
            en_q     <= '0;
            scnt_q   <= 16'd0;
            gap_q    <= 4'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_to_q <= 1'b0;
            err_sp_q <= 1'b0;
            last_q   <= 16'd0;
            frame_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            en_q     <= en_d;
            scnt_q   <= scnt_d;
            gap_q    <= gap_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_to_q <= err_to_d;
            err_sp_q <= err_sp_d;
            last_q   <= last_d;
            frame_q  <= frame_d;
        end
    end

    assign stage_en       = en_q;
    assign cur_stage      = idx_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err_timeout    = err_to_q;
    assign err_spurious   = err_sp_q;
    assign stage_cyc_last = last_q;
    assign frame_cyc      = frame_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_levit_stage_sequencer.sv
// Testbench for levit_stage_sequencer.
// Instance a: GAP_CYC=1, TIMEOUT_CYC=20. It covers the nominal frame,
// timeout, abort, spurious end, simultaneous end/timeout and async reset.
// Instance b: GAP_CYC=0, TIMEOUT_CYC=20. It covers the nominal frame only.
// Each stage model pulses its end bit a fixed number of enabled cycles
// after its enable rises.
module tb_levit_stage_sequencer;

    localparam int N     = 12;
    localparam int TO    = 20;
    localparam int GAP_A = 1;
    localparam int GAP_B = 0;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rstn;

    // ---------------- DUT signals ----------------
    logic         start_a, abort_a, busy_a, done_a, eto_a, esp_a;
    logic [N-1:0] end_a, en_a;
    logic [3:0]   cur_a;
    logic [15:0]  last_a;
    logic [23:0]  frame_a;
    logic [2:0]   st_a;

    logic         start_b, abort_b, busy_b, done_b, eto_b, esp_b;
    logic [N-1:0] end_b, en_b;
    logic [3:0]   cur_b;
    logic [15:0]  last_b;
    logic [23:0]  frame_b;
    logic [2:0]   st_b;

    levit_stage_sequencer #(.N_STAGE(N), .GAP_CYC(GAP_A), .TIMEOUT_CYC(TO), .CNT_W(24)) u_dut_a (
        .clk(clk), .rstn(rstn), .start(start_a), .abort(abort_a), .stage_end(end_a),
        .stage_en(en_a), .cur_stage(cur_a), .busy(busy_a), .done(done_a),
        .err_timeout(eto_a), .err_spurious(esp_a), .stage_cyc_last(last_a),
        .frame_cyc(frame_a), .state_dbg(st_a)
    );

    levit_stage_sequencer #(.N_STAGE(N), .GAP_CYC(GAP_B), .TIMEOUT_CYC(TO), .CNT_W(24)) u_dut_b (
        .clk(clk), .rstn(rstn), .start(start_b), .abort(abort_b), .stage_end(end_b),
        .stage_en(en_b), .cur_stage(cur_b), .busy(busy_b), .done(done_b),
        .err_timeout(eto_b), .err_spurious(esp_b), .stage_cyc_last(last_b),
        .frame_cyc(frame_b), .state_dbg(st_b)
    );

    // ---------------- scoreboard state ----------------
    int vectors     = 0;
    int miscompares = 0;

    // Enable-rise expectation: {check_gap, gap_len[3:0], stage_idx[3:0]}
    logic [8:0]  en_exp_q_a[$];
    logic [8:0]  en_exp_q_b[$];
    // Done expectation: {frame_cyc[23:0], stage_cyc_last[15:0]}
    logic [39:0] done_exp_q_a[$];
    logic [39:0] done_exp_q_b[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // ---------------- stage models (drive stage_end at negedge) ----------------
    int           end_at_a [N];
    int           end_at_b [N];
    logic [N-1:0] spur_a = '0;
    int           rcnt_a = 0, rcnt_b = 0;
    logic [N-1:0] rprev_a = '0, rprev_b = '0;

    always @(negedge clk) begin
        if (en_a != '0) rcnt_a = (en_a == rprev_a) ? rcnt_a + 1 : 1;
        else            rcnt_a = 0;
        rprev_a = en_a;
        end_a = spur_a;
        for (int i = 0; i < N; i++)
            if (en_a[i] && end_at_a[i] == rcnt_a) end_a = end_a | en_a;
    end

    always @(negedge clk) begin
        if (en_b != '0) rcnt_b = (en_b == rprev_b) ? rcnt_b + 1 : 1;
        else            rcnt_b = 0;
        rprev_b = en_b;
        end_b = '0;
        for (int i = 0; i < N; i++)
            if (en_b[i] && end_at_b[i] == rcnt_b) end_b = en_b;
    end

    // ---------------- monitors ----------------
    logic [N-1:0] mprev_a = '0, mprev_b = '0;
    int zrun_a = 0, zrun_b = 0, run_a = 0, last_run_a = 0, done_cnt_b = 0;

    always @(negedge clk) begin
        logic [8:0]  e;
        logic [39:0] d;
        if (!rstn) begin
            mprev_a = '0;
            zrun_a  = 0;
            run_a   = 0;
        end else begin
            check("a_onehot0_busy", 64'($onehot0(en_a) && (en_a == '0 || busy_a)), 64'd1);
            if (en_a != '0 && en_a != mprev_a) begin
                if (en_exp_q_a.size() == 0) begin
                    check("a_en_unexpected", 64'(en_a), 64'd0);
                end else begin
                    e = en_exp_q_a.pop_front();
                    check("a_en_stage", 64'(en_a), 64'(oh(int'(e[3:0]))));
                    check("a_cur_stage", 64'(cur_a), 64'(e[3:0]));
                    if (e[8]) check("a_gap_len", 64'(zrun_a), 64'(e[7:4]));
                end
            end
            if (en_a == '0) begin
                if (mprev_a != '0) last_run_a = run_a;
                run_a  = 0;
                zrun_a = zrun_a + 1;
            end else begin
                run_a  = (en_a == mprev_a) ? run_a + 1 : 1;
                zrun_a = 0;
            end
            mprev_a = en_a;
            if (done_a) begin
                if (done_exp_q_a.size() == 0) begin
                    check("a_done_unexpected", 64'd1, 64'd0);
                end else begin
                    d = done_exp_q_a.pop_front();
                    check("a_frame_cyc", 64'(frame_a), 64'(d[39:16]));
                    check("a_stage_cyc_last", 64'(last_a), 64'(d[15:0]));
                    check("a_done_cur_stage", 64'(cur_a), 64'(N - 1));
                    check("a_done_busy", 64'(busy_a), 64'd0);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [8:0]  e;
        logic [39:0] d;
        if (!rstn) begin
            mprev_b = '0;
            zrun_b  = 0;
        end else begin
            check("b_no_zero_mid_frame", 64'($onehot0(en_b) && (busy_b == (en_b != '0))), 64'd1);
            if (en_b != '0 && en_b != mprev_b) begin
                if (en_exp_q_b.size() == 0) begin
                    check("b_en_unexpected", 64'(en_b), 64'd0);
                end else begin
                    e = en_exp_q_b.pop_front();
                    check("b_en_stage", 64'(en_b), 64'(oh(int'(e[3:0]))));
                    if (e[8]) check("b_gap_len", 64'(zrun_b), 64'(e[7:4]));
                end
            end
            zrun_b  = (en_b == '0) ? zrun_b + 1 : 0;
            mprev_b = en_b;
            if (done_b) begin
                done_cnt_b++;
                if (done_exp_q_b.size() == 0) begin
                    check("b_done_unexpected", 64'd1, 64'd0);
                end else begin
                    d = done_exp_q_b.pop_front();
                    check("b_frame_cyc", 64'(frame_b), 64'(d[39:16]));
                    check("b_stage_cyc_last", 64'(last_b), 64'(d[15:0]));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rises_a(input int last_stage);
        for (int i = 0; i <= last_stage; i++)
            en_exp_q_a.push_back({(i != 0), 4'(GAP_A), 4'(i)});
    endtask

    task automatic wait_done_a(input int budget);
        int n = 0;
        while (!done_a && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("a_done_seen", 64'(done_a), 64'd1);
    endtask

    task automatic wait_en_a(input int bit_idx, input int budget);
        int n = 0;
        while (!en_a[bit_idx] && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("a_en_reached", 64'(en_a[bit_idx]), 64'd1);
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_stage_en"}, 64'(en_a), 64'd0);
        check({tag, "_cur_stage"}, 64'(cur_a), 64'd0);
        check({tag, "_busy"}, 64'(busy_a), 64'd0);
        check({tag, "_done"}, 64'(done_a), 64'd0);
        check({tag, "_err_timeout"}, 64'(eto_a), 64'd0);
        check({tag, "_err_spurious"}, 64'(esp_a), 64'd0);
        check({tag, "_stage_cyc_last"}, 64'(last_a), 64'd0);
        check({tag, "_frame_cyc"}, 64'(frame_a), 64'd0);
    endtask

    // ---------------- main stimulus ----------------
    initial begin
        rstn = 1'b0;
        start_a = 1'b0; abort_a = 1'b0;
        start_b = 1'b0; abort_b = 1'b0;
        for (int i = 0; i < N; i++) begin
            end_at_a[i] = 5;
            end_at_b[i] = 5;
        end

        // Reset state
        #23;
        check_reset_a("rst_a");
        check("rst_b_stage_en", 64'(en_b), 64'd0);
        check("rst_b_frame_cyc", 64'(frame_b), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        tick();

        // Nominal frame on both instances
        push_rises_a(N - 1);
        done_exp_q_a.push_back({24'd71, 16'd5});
        for (int i = 0; i < N; i++) en_exp_q_b.push_back({(i != 0), 4'(GAP_B), 4'(i)});
        done_exp_q_b.push_back({24'd60, 16'd5});
        start_a = 1'b1; start_b = 1'b1;
        tick();
        start_a = 1'b0; start_b = 1'b0;
        check("a_en_after_start", 64'(en_a), 64'd1);
        check("a_frame_after_start", 64'(frame_a), 64'd1);
        check("a_busy_after_start", 64'(busy_a), 64'd1);
        wait_done_a(300);
        @(negedge clk);
        check("a_done_one_cycle", 64'(done_a), 64'd0);
        check("a_idle_cur_stage", 64'(cur_a), 64'(N - 1));
        check("a_nominal_err_timeout", 64'(eto_a), 64'd0);
        check("a_nominal_err_spurious", 64'(esp_a), 64'd0);
        check("b_done_count", 64'(done_cnt_b), 64'd1);
        tick();

        // Timeout: stage 3 never ends
        end_at_a[3] = 0;
        push_rises_a(3);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int n = 0; n < 200 && !eto_a; n++) @(negedge clk);
        @(negedge clk);
        check("to_err_timeout", 64'(eto_a), 64'd1);
        check("to_stage_en", 64'(en_a), 64'd0);
        check("to_cur_stage", 64'(cur_a), 64'd3);
        check("to_busy", 64'(busy_a), 64'd0);
        check("to_enabled_cycles", 64'(last_run_a), 64'(TO));
        check("to_frame_cyc", 64'(frame_a), 64'd38);
        check("to_stage_cyc_last", 64'(last_a), 64'd5);
        end_at_a[3] = 5;
        tick();
        push_rises_a(N - 1);
        done_exp_q_a.push_back({24'd71, 16'd5});
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("to_restart_err_timeout", 64'(eto_a), 64'd0);
        check("to_restart_stage_en", 64'(en_a), 64'd1);
        wait_done_a(300);
        tick();

        // Abort while stage 7 is enabled, then restart one cycle later
        push_rises_a(7);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        wait_en_a(7, 300);
        tick();
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        check("ab_stage_en", 64'(en_a), 64'd0);
        check("ab_busy", 64'(busy_a), 64'd0);
        check("ab_done", 64'(done_a), 64'd0);
        check("ab_cur_stage", 64'(cur_a), 64'd7);
        check("ab_frame_cyc", 64'(frame_a), 64'd44);
        check("ab_stage_cyc_last", 64'(last_a), 64'd5);
        push_rises_a(N - 1);
        done_exp_q_a.push_back({24'd71, 16'd5});
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("ab_restart_stage_en", 64'(en_a), 64'd1);
        wait_done_a(300);
        tick();

        // Spurious end, start during RUN, stage 2 ends as its counter hits TO
        end_at_a[2] = TO;
        push_rises_a(N - 1);
        done_exp_q_a.push_back({24'd86, 16'd5});
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        wait_en_a(2, 300);
        tick();
        spur_a = oh(9);
        start_a = 1'b1;
        tick();
        spur_a = '0;
        start_a = 1'b0;
        check("sp_err_spurious", 64'(esp_a), 64'd1);
        check("sp_cur_stage", 64'(cur_a), 64'd2);
        wait_done_a(400);
        check("sp_err_spurious_sticky", 64'(esp_a), 64'd1);
        check("sp_no_timeout", 64'(eto_a), 64'd0);
        end_at_a[2] = 5;
        tick();

        // Asynchronous reset in the middle of stage 5
        push_rises_a(5);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        wait_en_a(5, 300);
        #2;
        rstn = 1'b0;
        #1;
        check_reset_a("arst");
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        check_reset_a("arst_hold");

        // Every expectation must have been consumed
        check("a_en_q_empty", 64'(en_exp_q_a.size()), 64'd0);
        check("a_done_q_empty", 64'(done_exp_q_a.size()), 64'd0);
        check("b_en_q_empty", 64'(en_exp_q_b.size()), 64'd0);
        check("b_done_q_empty", 64'(done_exp_q_b.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
